// File: rtl/player_2_sync_ctrl.sv
// -----------------------------------------------------------------------------
// player_2_sync_ctrl
//
// Builds remote-player position packets from a UART byte stream and checks
// each packet's checksum. Good packets go into shadow registers. The shadow
// values are copied to the sprite renderer only at the rising edge of vertical
// blank, so the sprite never updates mid-frame. A frame counter tracks how
// long the link has been silent and drops player_2_present after
// TIMEOUT_FRAMES frame starts with no commit.
//
// Packet format: HDR, {class,flip,0,x[11:8]}, x[7:0], {4'h0,y[11:8]}, y[7:0],
// then XOR of the four body bytes.
//
// Ports:
//   clk                  in   system/pixel clock
//   rst                  in   asynchronous active-high reset
//   rx_data[7:0]         in   received byte (qualified by rx_valid)
//   rx_valid             in   one-cycle strobe per received byte
//   vblnk                in   vertical blank from the VGA timing chain
//   player_2_x[11:0]     out  committed sprite centre x
//   player_2_y[11:0]     out  committed sprite centre y
//   player_2_flip_h      out  committed horizontal mirror flag
//   player_2_class[1:0]  out  committed character class
//   player_2_data_valid  out  one-cycle pulse per commit
//   player_2_present     out  high while the link is alive
//   pkt_err_cnt[7:0]     out  saturating count of checksum failures
// -----------------------------------------------------------------------------
module player_2_sync_ctrl #(
  parameter int          TIMEOUT_FRAMES = 60,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        vblnk,
  output logic [11:0] player_2_x,
  output logic [11:0] player_2_y,
  output logic        player_2_flip_h,
  output logic [1:0]  player_2_class,
  output logic        player_2_data_valid,
  output logic        player_2_present,
  output logic [7:0]  pkt_err_cnt
);

  // The counter must be able to hold TIMEOUT_FRAMES itself, because it
  // saturates at that value.
  localparam int                CNT_W       = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_BODY = 2'd1,
    ST_CSUM = 2'd2
  } rx_state_t;

  // Running checksum: fold one more byte into the XOR accumulator.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    xor_fold = acc ^ b;
  endfunction

  // Receive FSM state and byte index
  rx_state_t   state;
  rx_state_t   state_next;
  logic [2:0]  idx;
  logic [2:0]  idx_next;

  // Decoded per-cycle FSM actions
  logic        hdr_seen;
  logic        byte_store;
  logic        pkt_ok;
  logic        pkt_bad;

  // Assembly registers. Only the meaningful fields are kept. The reserved bits
  // still count toward the checksum through csum_acc.
  logic [7:0]  csum_acc;
  logic [1:0]  asm_class;
  logic        asm_flip;
  logic [3:0]  asm_x_hi;
  logic [7:0]  asm_x_lo;
  logic [3:0]  asm_y_hi;
  logic [7:0]  asm_y_lo;

  // Shadow registers holding the latest accepted, not yet committed packet
  logic [11:0] sh_x;
  logic [11:0] sh_y;
  logic        sh_flip;
  logic [1:0]  sh_class;
  logic        pending;

  // Frame-start detection and liveness tracking
  logic              vblnk_q;
  logic              fs;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  cnt_inc;

  assign fs = vblnk & ~vblnk_q;

  // Next-state and action decode for the receive FSM. It moves only on rx_valid.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    hdr_seen   = 1'b0;
    byte_store = 1'b0;
    pkt_ok     = 1'b0;
    pkt_bad    = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_HUNT: begin
          if (rx_data == HDR_BYTE) begin
            hdr_seen   = 1'b1;
            state_next = ST_BODY;
            idx_next   = 3'd1;
          end else begin
            state_next = ST_HUNT;
          end
        end
        ST_BODY: begin
          // A header value inside the body is ordinary data. The FSM never resyncs mid-packet.
          byte_store = 1'b1;
          if (idx == 3'd4) begin
            state_next = ST_CSUM;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
        ST_CSUM: begin
          state_next = ST_HUNT;
          if (rx_data == csum_acc) begin
            pkt_ok = 1'b1;
          end else begin
            pkt_bad = 1'b1;
          end
        end
        default: begin
          state_next = ST_HUNT;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Saturating increment of the silent-frame counter
  always_comb begin
    if (frame_cnt < TIMEOUT_VAL) begin
      cnt_inc = frame_cnt + CNT_W'(1);
    end else begin
      cnt_inc = frame_cnt;
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
      idx   <= 3'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Packet assembly and running checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_acc  <= 8'h00;
      asm_class <= 2'd0;
      asm_flip  <= 1'b0;
      asm_x_hi  <= 4'h0;
      asm_x_lo  <= 8'h00;
      asm_y_hi  <= 4'h0;
      asm_y_lo  <= 8'h00;
    end else begin
      if (hdr_seen) begin
        csum_acc <= 8'h00;
      end else if (byte_store) begin
        csum_acc <= xor_fold(csum_acc, rx_data);
      end
      if (byte_store) begin
        case (idx)
          3'd1: begin
            asm_class <= rx_data[7:6];
            asm_flip  <= rx_data[5];
            asm_x_hi  <= rx_data[3:0];
          end
          3'd2: asm_x_lo <= rx_data;
          3'd3: asm_y_hi <= rx_data[3:0];
          3'd4: asm_y_lo <= rx_data;
          default: begin
            asm_y_lo <= asm_y_lo;
          end
        endcase
      end
    end
  end

  // Registered vblnk, used for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
    end
  end

  // Shadow load, frame-synchronous commit, liveness and error counting.
  // The commit reads the shadow registers and pending from before this edge.
  // A packet that completes on the same edge therefore loads the shadows and
  // re-arms pending, and it commits at the next frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_x                <= 12'h000;
      sh_y                <= 12'h000;
      sh_flip             <= 1'b0;
      sh_class            <= 2'd0;
      pending             <= 1'b0;
      frame_cnt           <= '0;
      player_2_x          <= 12'h000;
      player_2_y          <= 12'h000;
      player_2_flip_h     <= 1'b0;
      player_2_class      <= 2'd0;
      player_2_data_valid <= 1'b0;
      player_2_present    <= 1'b0;
      pkt_err_cnt         <= 8'h00;
    end else begin
      player_2_data_valid <= 1'b0;

      if (fs && pending) begin
        player_2_x          <= sh_x;
        player_2_y          <= sh_y;
        player_2_flip_h     <= sh_flip;
        player_2_class      <= sh_class;
        player_2_data_valid <= 1'b1;
        player_2_present    <= 1'b1;
        pending             <= 1'b0;
        frame_cnt           <= '0;
      end else if (fs) begin
        frame_cnt <= cnt_inc;
        if (cnt_inc == TIMEOUT_VAL) begin
          player_2_present <= 1'b0;
        end
      end

      // The last valid packet wins. It may overwrite a packet that is still pending.
      if (pkt_ok) begin
        sh_x     <= {asm_x_hi, asm_x_lo};
        sh_y     <= {asm_y_hi, asm_y_lo};
        sh_flip  <= asm_flip;
        sh_class <= asm_class;
        pending  <= 1'b1;
      end

      if (pkt_bad && (pkt_err_cnt != 8'hFF)) begin
        pkt_err_cnt <= pkt_err_cnt + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_player_2_sync_ctrl.sv
module tb_player_2_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        vblnk;
  logic [11:0] player_2_x;
  logic [11:0] player_2_y;
  logic        player_2_flip_h;
  logic [1:0]  player_2_class;
  logic        player_2_data_valid;
  logic        player_2_present;
  logic [7:0]  pkt_err_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  player_2_sync_ctrl #(.TIMEOUT_FRAMES(3), .HDR_BYTE(8'hA5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .vblnk               (vblnk),
    .player_2_x          (player_2_x),
    .player_2_y          (player_2_y),
    .player_2_flip_h     (player_2_flip_h),
    .player_2_class      (player_2_class),
    .player_2_data_valid (player_2_data_valid),
    .player_2_present    (player_2_present),
    .pkt_err_cnt         (pkt_err_cnt)
  );

  typedef struct {
    logic        lead;     // send garbage 11,22 before the header
    logic [7:0]  b1, b2, b3, b4, cs;
    logic        dv;
    logic [11:0] x, y;
    logic [1:0]  cls;
    logic        flip;
    logic [7:0]  err;
    logic        present;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b1, b2, b3, b4, cs);
    send_byte(8'hA5);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(cs);
  endtask

  // Hold vblnk high for 3 cycles, then low for 1. Returns the data_valid value
  // one cycle after the rise, and the total number of data_valid pulses.
  task automatic do_frame(output logic dv_first, output int pulses);
    pulses = 0;
    vblnk = 1'b1;
    tick();
    dv_first = player_2_data_valid;
    pulses += int'(player_2_data_valid);
    tick();
    pulses += int'(player_2_data_valid);
    tick();
    pulses += int'(player_2_data_valid);
    vblnk = 1'b0;
    tick();
    pulses += int'(player_2_data_valid);
  endtask

  initial begin
    logic dv1;
    int   np;

    vecs[0] = '{1'b0, 8'h8F, 8'h34, 8'h00, 8'hC8, 8'h71, 1'b1, 12'hF34, 12'h2C8, 2'd2, 1'b0, 8'd0, 1'b1};
    vecs[1] = '{1'b0, 8'h8F, 8'h34, 8'h00, 8'hC8, 8'h00, 1'b0, 12'hF34, 12'h2C8, 2'd2, 1'b0, 8'd1, 1'b1};
    vecs[2] = '{1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 1'b1, 12'h000, 12'h000, 2'd0, 1'b1, 8'd1, 1'b1};
    vecs[3] = '{1'b0, 8'h51, 8'h23, 8'hF4, 8'h56, 8'hD0, 1'b1, 12'h123, 12'h456, 2'd1, 1'b0, 8'd1, 1'b1};
    vecs[4] = '{1'b0, 8'hE5, 8'hA5, 8'h00, 8'hA5, 8'hE5, 1'b1, 12'h5A5, 12'h0A5, 2'd3, 1'b1, 8'd1, 1'b1};
    vecs[5] = '{1'b1, 8'hA7, 8'hFF, 8'h0F, 8'hFF, 8'hA8, 1'b1, 12'h7FF, 12'hFFF, 2'd2, 1'b1, 8'd1, 1'b1};
    // The test-plan packet carries B3=02. Entries 0 and 1 use that value.
    vecs[0].b3 = 8'h02;
    vecs[1].b3 = 8'h02;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; vblnk = 1'b0;
    tick(); tick();
    check("rst_x", 32'(player_2_x), 32'h0);
    check("rst_y", 32'(player_2_y), 32'h0);
    check("rst_dv", 32'(player_2_data_valid), 32'h0);
    check("rst_present", 32'(player_2_present), 32'h0);
    check("rst_err", 32'(pkt_err_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // Table-driven packets, one frame each
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].lead) begin
        send_byte(8'h11);
        send_byte(8'h22);
      end
      send_pkt(vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4, vecs[i].cs);
      do_frame(dv1, np);
      check($sformatf("v%0d_dv", i), 32'(dv1), 32'(vecs[i].dv));
      check($sformatf("v%0d_pulses", i), 32'(np), 32'(vecs[i].dv));
      check($sformatf("v%0d_x", i), 32'(player_2_x), 32'(vecs[i].x));
      check($sformatf("v%0d_y", i), 32'(player_2_y), 32'(vecs[i].y));
      check($sformatf("v%0d_cls", i), 32'(player_2_class), 32'(vecs[i].cls));
      check($sformatf("v%0d_flip", i), 32'(player_2_flip_h), 32'(vecs[i].flip));
      check($sformatf("v%0d_err", i), 32'(pkt_err_cnt), 32'(vecs[i].err));
      check($sformatf("v%0d_present", i), 32'(player_2_present), 32'(vecs[i].present));
    end

    // Two packets (x=100, then x=200) before one frame start: a single commit of the later one
    send_pkt(8'h00, 8'h64, 8'h00, 8'h10, 8'h74);
    send_pkt(8'h00, 8'hC8, 8'h00, 8'h10, 8'hD8);
    do_frame(dv1, np);
    check("lastwins_pulses", 32'(np), 32'd1);
    check("lastwins_x", 32'(player_2_x), 32'h0C8);
    check("lastwins_y", 32'(player_2_y), 32'h010);

    // Liveness timeout with TIMEOUT_FRAMES=3
    do_frame(dv1, np);
    check("to1_present", 32'(player_2_present), 32'd1);
    do_frame(dv1, np);
    check("to2_present", 32'(player_2_present), 32'd1);
    do_frame(dv1, np);
    check("to3_present", 32'(player_2_present), 32'd0);
    check("to3_x_held", 32'(player_2_x), 32'h0C8);
    check("to3_dv", 32'(np), 32'd0);
    send_pkt(8'h00, 8'h64, 8'h00, 8'h10, 8'h74);
    do_frame(dv1, np);
    check("to_recover_present", 32'(player_2_present), 32'd1);
    check("to_recover_x", 32'(player_2_x), 32'h064);

    // Packet completes on the same edge as the frame start
    send_pkt(8'h01, 8'h11, 8'h01, 8'h11, 8'h00);      // P pending, x=111
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h22);
    send_byte(8'h02);
    send_byte(8'h22);
    rx_data = 8'h00; rx_valid = 1'b1; vblnk = 1'b1;   // Q checksum together with fs
    tick();
    rx_valid = 1'b0;
    check("samecyc_dv", 32'(player_2_data_valid), 32'd1);
    check("samecyc_x_old", 32'(player_2_x), 32'h111);
    tick();
    vblnk = 1'b0;
    tick();
    do_frame(dv1, np);
    check("samecyc_next_dv", 32'(dv1), 32'd1);
    check("samecyc_next_x", 32'(player_2_x), 32'h222);

    // Error counter saturates at FF (starting from 1)
    for (int k = 0; k < 300; k++) begin
      send_pkt(8'h8F, 8'h34, 8'h02, 8'hC8, 8'h00);
    end
    check("err_sat", 32'(pkt_err_cnt), 32'hFF);

    // Asynchronous reset in the middle of a packet
    send_byte(8'hA5);
    send_byte(8'h63);
    send_byte(8'h21);
    send_byte(8'h06);
    rst = 1'b1;
    #2;
    check("arst_x", 32'(player_2_x), 32'h0);
    check("arst_err", 32'(pkt_err_cnt), 32'h0);
    check("arst_present", 32'(player_2_present), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h54);                                  // stray B4
    send_byte(8'h10);                                  // stray B5
    send_pkt(8'h63, 8'h21, 8'h06, 8'h54, 8'h10);
    do_frame(dv1, np);
    check("arst_commit_dv", 32'(np), 32'd1);
    check("arst_commit_x", 32'(player_2_x), 32'h321);
    check("arst_commit_y", 32'(player_2_y), 32'h654);
    check("arst_commit_cls", 32'(player_2_class), 32'd1);
    check("arst_commit_flip", 32'(player_2_flip_h), 32'd1);
    check("arst_commit_err", 32'(pkt_err_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
